audio_framer: RTL

AUDIO_FRAMER -- requirements
Module: audio_framer

---
 rtl/audio_pkg.sv | 26 ++
 rtl/sync_fifo.sv | 55 +++++
 rtl/audio_framer.sv | 133 +++++++++++++
 3 files changed

// File: rtl/audio_pkg.sv
// Shared widths, state encoding and counter helper for the audio framer.
package audio_pkg;

   localparam int SAMPLE_W = 16;
   localparam int AXIS_W   = 32;
   localparam int CNT_W    = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2
   } framer_state_t;

   // Modulo counter step: returns 0 after the last index, otherwise cnt + 1.
   function automatic logic [CNT_W-1:0] wrap_inc(input logic [CNT_W-1:0] cnt,
                                                  input logic [CNT_W-1:0] last);
      logic [CNT_W-1:0] res;
      if (cnt == last) begin
         res = {CNT_W{1'b0}};
      end else begin
         res = cnt + 16'd1;
      end
      return res;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO. Pointers carry one extra MSB so
// that full and empty are told apart when the address bits are equal.
module sync_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             empty,
   output logic             full
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             wr_ok;
   logic             rd_ok;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign rd_ok   = rd_en && !empty;
   // A write into a full FIFO is only legal when a word leaves in the same cycle.
   assign wr_ok   = wr_en && (!full || rd_ok);
   assign rd_data = mem[rd_ptr[AW-1:0]];

   // Advance read and write pointers on accepted operations.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_ok) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (rd_ok) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
      end
   end

   // Storage array write port.
   always_ff @(posedge clk) begin
      if (wr_ok) begin
         mem[wr_ptr[AW-1:0]] <= wr_data;
      end
   end

endmodule

// File: rtl/audio_framer.sv
// Audio framer: captures strobed stereo samples into a FIFO and emits them as
// an AXI-Stream with tlast marking every FRAME_LEN-th beat.
module audio_framer
   import audio_pkg::*;
#(
   parameter int FRAME_LEN  = 1024,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                axis_aclk,
   input  logic                axis_areset,
   input  logic                enable,
   input  logic                sample_strobe,
   input  logic [SAMPLE_W-1:0] sample_left,
   input  logic [SAMPLE_W-1:0] sample_right,
   input  logic                out_axis_tready,
   output logic [AXIS_W-1:0]   out_axis_tdata,
   output logic                out_axis_tvalid,
   output logic                out_axis_tlast,
   output logic                busy,
   output logic [CNT_W-1:0]    drop_count
);

   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

   logic [1:0]        rst_sync;
   logic              rst_int;
   framer_state_t     state;
   framer_state_t     state_next;
   logic [CNT_W-1:0]  in_cnt;
   logic [CNT_W-1:0]  in_cnt_next;
   logic [CNT_W-1:0]  beat_cnt;
   logic [AXIS_W-1:0] fifo_data;
   logic              fifo_empty;
   logic              fifo_full;
   logic              live;
   logic              handshake;
   logic              accept;
   logic              drop;

   // Reset synchroniser: asserts immediately, releases two edges later.
   always_ff @(posedge axis_aclk or posedge axis_areset) begin
      if (axis_areset) begin
         rst_sync <= 2'b11;
      end else begin
         rst_sync <= {rst_sync[0], 1'b0};
      end
   end

   assign rst_int = rst_sync[1];

   sync_fifo #(
      .WIDTH (AXIS_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (axis_aclk),
      .rst     (rst_int),
      .wr_en   (accept),
      .wr_data ({sample_left, sample_right}),
      .rd_en   (handshake),
      .rd_data (fifo_data),
      .empty   (fifo_empty),
      .full    (fifo_full)
   );

   // Strobe qualification: accept, or drop when full with nothing leaving.
   always_comb begin
      live      = sample_strobe && ((state == RUN) || (state == FLUSH));
      handshake = !fifo_empty && out_axis_tready;
      accept    = live && (!fifo_full || handshake);
      drop      = live && fifo_full && !handshake;
      if (accept) begin
         in_cnt_next = wrap_inc(in_cnt, LAST_IDX);
      end else begin
         in_cnt_next = in_cnt;
      end
   end

   // Capture FSM; frame completion is judged on the post-update in-frame count.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (enable) begin
               state_next = RUN;
            end else begin
               state_next = IDLE;
            end
         end
         RUN: begin
            if (!enable) begin
               state_next = (in_cnt_next == 16'd0) ? IDLE : FLUSH;
            end else begin
               state_next = RUN;
            end
         end
         FLUSH: begin
            if (in_cnt_next == 16'd0) begin
               state_next = IDLE;
            end else begin
               state_next = FLUSH;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // State, in-frame count, output beat count and saturating drop count.
   always_ff @(posedge axis_aclk or posedge rst_int) begin
      if (rst_int) begin
         state      <= IDLE;
         in_cnt     <= 16'd0;
         beat_cnt   <= 16'd0;
         drop_count <= 16'd0;
      end else begin
         state  <= state_next;
         in_cnt <= in_cnt_next;
         if (handshake) begin
            beat_cnt <= wrap_inc(beat_cnt, LAST_IDX);
         end
         if (drop && (drop_count != 16'hFFFF)) begin
            drop_count <= drop_count + 16'd1;
         end
      end
   end

   assign out_axis_tvalid = !fifo_empty;
   assign out_axis_tdata  = fifo_empty ? 32'd0 : fifo_data;
   assign out_axis_tlast  = !fifo_empty && (beat_cnt == LAST_IDX);
   assign busy            = (state != IDLE) || !fifo_empty;

endmodule
